climate_ctrl: RTL and testbench
===============================

Name: climate_ctrl

Overview:
Closed-loop actuator controller fed by the DHT11 reader's temperature, humidity and data-ready outputs.
- Validates each sample and applies hysteresis thresholds to drive the cooling fan and humidifier outputs.
- Enforces a minimum on/off dwell time per actuator.
- Handles the auto/manual mode button and flags a stale or faulty sensor.
- Sits between the sensor reader and the LED/actuator pins in the 1 MHz clock domain.

Parameters:
CLK_HZ, 1_000_000, input clock frequency; sets the 1 s and 1 ms prescalers.
TEMP_ON, 8, fan request asserts when temperature >= this value (°C).
TEMP_OFF, 5, fan request deasserts when temperature <= this value; must be < TEMP_ON.
HUM_ON, 85, humidifier request asserts when humidity <= this value (%RH).
HUM_OFF, 92, humidifier request deasserts when humidity >= this value; must be > HUM_ON.
TEMP_MAX, 50, temperatures above this are rejected as implausible.
MIN_DWELL_S, 10, minimum seconds an actuator holds a state before it may change.
STALE_S, 5, seconds without an accepted sample before sensor_fault asserts.
DEBOUNCE_MS, 20, time mode_btn must be stable before its level is accepted.

Ports:
clk  in  1  1 MHz system clock.
rst_n  in  1  Asynchronous, active-high reset; the block is in reset while this is 1.
sample_valid  in  1  One-cycle pulse; temperature and humidity are valid in this cycle.
temperature  in  8  Integer °C from the sensor reader.
humidity  in  8  Integer %RH from the sensor reader.
mode_btn  in  1  Raw, asynchronous push-button; 1 = pressed.
man_fan  in  1  Raw manual fan switch, used in manual mode.
man_hum  in  1  Raw manual humidifier switch, used in manual mode.
mode_auto  out  1  1 = auto, 0 = manual.
fan_on  out  1  Cooling fan drive.
hum_on  out  1  Humidifier drive.
sensor_fault  out  1  1 = no accepted sample within STALE_S seconds.
sample_reject  out  1  One-cycle pulse when an incoming sample is rejected.

Behaviour:
- Reset values: mode_auto=1, fan_on=0, hum_on=0, sensor_fault=0, sample_reject=0. Fan and humidifier request registers reset to 0; all counters reset to 0; dwell counters reset to expired.
- Prescalers: a free-running counter produces a 1-cycle tick_1s every CLK_HZ cycles and tick_1ms every CLK_HZ/1000 cycles.
- Input conditioning: mode_btn, man_fan and man_hum each pass through a 2-FF synchronizer.
- mode_btn debounce: the synchronized level must be stable for DEBOUNCE_MS consecutive tick_1ms before it is accepted. Each debounced 0->1 edge toggles mode_auto.
- Sample acceptance: a sample is accepted when sample_valid=1, temperature <= TEMP_MAX and humidity <= 100. A sample failing either check is rejected: sample_reject pulses in the next cycle and no state changes.
- Hysteresis: evaluated on every accepted sample, one cycle after sample_valid, in both modes.
  - fan_req: set if temperature >= TEMP_ON, cleared if temperature <= TEMP_OFF, otherwise held.
  - hum_req: set if humidity <= HUM_ON, cleared if humidity >= HUM_OFF, otherwise held.
- Target selection:
  - Auto mode: target = fan_req / hum_req.
  - Manual mode: target = synchronized man_fan / man_hum.
  - sensor_fault=1 in auto mode: target fan=1, hum=0 (fail-safe cooling).
  - Manual mode ignores sensor_fault.
- Dwell FSM per actuator, states OFF and ON:
  - Entering either state loads dwell=MIN_DWELL_S; dwell decrements on each tick_1s while nonzero.
  - Transition happens when target != state and dwell==0; the output changes in the cycle after that condition holds.
  - Exception: the rising edge of sensor_fault in auto mode forces fan ON / hum OFF immediately, ignoring dwell, then reloads dwell.
- Stale watchdog:
  - Counter increments on each tick_1s and clears on every accepted sample.
  - When the counter reaches STALE_S, sensor_fault is set and the counter saturates.
  - sensor_fault clears in the cycle after the next accepted sample; the actuators then follow their dwell rules.
- Simultaneous events:
  - Accepted sample in the same cycle as the STALE_S tick: the sample wins and the fault does not assert.
  - Debounced mode edge in the same cycle as a sample: both take effect.
  - Mode change never bypasses dwell.
- Reset mid-dwell or mid-debounce returns the block to reset values immediately (asynchronously).

Decomposition:
- Shared package climate_pkg holds:
  - dwell state encoding (ST_OFF, ST_ON);
  - threshold defaults;
  - TEMP_MAX;
  - the humidity ceiling (100).
- Sub-module actuator_dwell (ports: clk, rst_n, tick_1s, target, force, force_val, state_out), instantiated twice (fan and humidifier).
- Prescalers, debounce, hysteresis and watchdog stay in climate_ctrl.

Test Plan:
All scenarios run with CLK_HZ=1000, MIN_DWELL_S=2, STALE_S=3, DEBOUNCE_MS=2.
- Reset, then a sample of temp=9, hum=90 -> fan_on=1 within 2 cycles (dwell expired at reset); hum_on stays 0 because 90 lies in the hold band.
- Samples at temp=9, then 6, then 4 at 0.5 s intervals -> fan_on stays 1 through the 6 sample; it drops at the 4 sample only once 2 s have elapsed since turn-on.
- Sample of temp=60 or hum=101 -> sample_reject pulses 1 cycle; outputs and watchdog unchanged; fault asserts 3 s after the last accepted sample.
- No samples for 3 s in auto mode with fan_on=0, hum_on=1 -> sensor_fault=1; fan_on=1 and hum_on=0 on the next cycle despite the dwell; a valid sample (temp=3, hum=88) clears the fault and fan_on drops after dwell.
- mode_btn glitch of 1 ms -> no mode change. A 5 ms press toggles mode_auto to 0, after which fan_on follows man_fan subject to the 2 s dwell. A second press restores mode_auto=1.
- Sample of temp=20 in the same cycle as the stale tick at count 3 -> sensor_fault stays 0 and fan_req=1.

Source files
------------

// File: rtl/climate_pkg.sv
// Shared definitions for the climate controller: dwell state encoding,
// threshold defaults, sample plausibility limits and a counter-width helper.
package climate_pkg;

    typedef enum logic {
        ST_OFF = 1'b0,
        ST_ON  = 1'b1
    } dwell_state_e;

    // Default hysteresis thresholds (degC / %RH)
    localparam int TEMP_ON_DEF  = 8;
    localparam int TEMP_OFF_DEF = 5;
    localparam int HUM_ON_DEF   = 85;
    localparam int HUM_OFF_DEF  = 92;

    // Plausibility limits for incoming samples
    localparam int TEMP_MAX_DEF = 50;
    localparam int HUM_CEIL     = 100;

    // Default timing
    localparam int MIN_DWELL_DEF = 10;
    localparam int STALE_DEF     = 5;
    localparam int DEBOUNCE_DEF  = 20;

    // Bits needed to hold 0..n-1, never less than one bit
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/climate_ctrl_dwell.sv
// One actuator with a minimum dwell time in each state. A force request
// overrides the dwell and moves straight to force_val. rst_n is active-high.
module actuator_dwell
    import climate_pkg::*;
#(
    parameter int MIN_DWELL_S = MIN_DWELL_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick_1s,
    input  logic target,
    input  logic force_en,
    input  logic force_val,
    output logic state_out
);

    localparam int DW_W = cnt_width(MIN_DWELL_S + 1);

    dwell_state_e    r_state;
    logic [DW_W-1:0] r_dwell;
    logic            w_want_change;

    assign w_want_change = (target != (r_state == ST_ON)) && (r_dwell == '0);

    // State register: force wins, then dwell-gated transition, then countdown
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_state <= ST_OFF;
            r_dwell <= '0;
        end else if (force_en) begin
            r_state <= dwell_state_e'(force_val);
            r_dwell <= DW_W'(MIN_DWELL_S);
        end else if (w_want_change) begin
            r_state <= dwell_state_e'(target);
            r_dwell <= DW_W'(MIN_DWELL_S);
        end else if (tick_1s && (r_dwell != '0)) begin
            r_dwell <= r_dwell - 1'b1;
        end
    end

    assign state_out = (r_state == ST_ON);

endmodule

// File: rtl/climate_ctrl.sv
// Closed-loop fan/humidifier controller: sample validation, hysteresis,
// mode button debounce, stale-sensor watchdog and per-actuator dwell.
// rst_n is an asynchronous active-high reset.
module climate_ctrl
    import climate_pkg::*;
#(
    parameter int CLK_HZ      = 1_000_000,
    parameter int TEMP_ON     = TEMP_ON_DEF,
    parameter int TEMP_OFF    = TEMP_OFF_DEF,
    parameter int HUM_ON      = HUM_ON_DEF,
    parameter int HUM_OFF     = HUM_OFF_DEF,
    parameter int TEMP_MAX    = TEMP_MAX_DEF,
    parameter int MIN_DWELL_S = MIN_DWELL_DEF,
    parameter int STALE_S     = STALE_DEF,
    parameter int DEBOUNCE_MS = DEBOUNCE_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sample_valid,
    input  logic [7:0] temperature,
    input  logic [7:0] humidity,
    input  logic       mode_btn,
    input  logic       man_fan,
    input  logic       man_hum,
    output logic       mode_auto,
    output logic       fan_on,
    output logic       hum_on,
    output logic       sensor_fault,
    output logic       sample_reject
);

    localparam int MS_DIV  = CLK_HZ / 1000;
    localparam int SEC_W   = cnt_width(CLK_HZ);
    localparam int MS_W    = cnt_width(MS_DIV);
    localparam int DB_W    = cnt_width(DEBOUNCE_MS);
    localparam int STALE_W = cnt_width(STALE_S + 1);

    logic [SEC_W-1:0]   r_sec_cnt;
    logic [MS_W-1:0]    r_ms_cnt;
    logic [2:0]         r_sync1;
    logic [2:0]         r_sync2;
    logic               r_btn_level;
    logic [DB_W-1:0]    r_db_cnt;
    logic               r_mode_auto;
    logic               r_fan_req;
    logic               r_hum_req;
    logic               r_sample_reject;
    logic [STALE_W-1:0] r_stale_cnt;
    logic               r_fault;
    logic               r_fault_d;

    logic w_tick_1s;
    logic w_tick_1ms;
    logic w_btn_sync;
    logic w_man_fan_sync;
    logic w_man_hum_sync;
    logic w_accept;
    logic w_reject;
    logic w_fan_target;
    logic w_hum_target;
    logic w_force;
    logic w_fan_state;
    logic w_hum_state;

    assign w_tick_1s  = (r_sec_cnt == SEC_W'(CLK_HZ - 1));
    assign w_tick_1ms = (r_ms_cnt == MS_W'(MS_DIV - 1));

    // Free-running 1 s and 1 ms prescalers
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_sec_cnt <= '0;
            r_ms_cnt  <= '0;
        end else begin
            r_sec_cnt <= w_tick_1s  ? '0 : r_sec_cnt + 1'b1;
            r_ms_cnt  <= w_tick_1ms ? '0 : r_ms_cnt + 1'b1;
        end
    end

    // Two-flop synchronizers for the raw button and manual switches
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= {mode_btn, man_fan, man_hum};
            r_sync2 <= r_sync1;
        end
    end

    assign w_btn_sync     = r_sync2[2];
    assign w_man_fan_sync = r_sync2[1];
    assign w_man_hum_sync = r_sync2[0];

    // Button debounce on ms ticks; each accepted press toggles the mode
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_btn_level <= 1'b0;
            r_db_cnt    <= '0;
            r_mode_auto <= 1'b1;
        end else if (w_tick_1ms) begin
            if (w_btn_sync == r_btn_level) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == DB_W'(DEBOUNCE_MS - 1)) begin
                r_db_cnt    <= '0;
                r_btn_level <= w_btn_sync;
                if (w_btn_sync) begin
                    r_mode_auto <= ~r_mode_auto;
                end
            end else begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end
        end
    end

    assign w_accept = sample_valid && (temperature <= 8'(TEMP_MAX)) &&
                      (humidity <= 8'(HUM_CEIL));
    assign w_reject = sample_valid && !w_accept;

    // Reject pulse and hysteresis requests, updated only by accepted samples
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_sample_reject <= 1'b0;
            r_fan_req       <= 1'b0;
            r_hum_req       <= 1'b0;
        end else begin
            r_sample_reject <= w_reject;
            if (w_accept) begin
                if (temperature >= 8'(TEMP_ON)) begin
                    r_fan_req <= 1'b1;
                end else if (temperature <= 8'(TEMP_OFF)) begin
                    r_fan_req <= 1'b0;
                end
                if (humidity <= 8'(HUM_ON)) begin
                    r_hum_req <= 1'b1;
                end else if (humidity >= 8'(HUM_OFF)) begin
                    r_hum_req <= 1'b0;
                end
            end
        end
    end

    // Stale watchdog: seconds since last accepted sample, saturating at fault
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_stale_cnt <= '0;
            r_fault     <= 1'b0;
            r_fault_d   <= 1'b0;
        end else begin
            r_fault_d <= r_fault;
            if (w_accept) begin
                r_stale_cnt <= '0;
                r_fault     <= 1'b0;
            end else if (w_tick_1s && !r_fault) begin
                if (r_stale_cnt == STALE_W'(STALE_S - 1)) begin
                    r_stale_cnt <= STALE_W'(STALE_S);
                    r_fault     <= 1'b1;
                end else begin
                    r_stale_cnt <= r_stale_cnt + 1'b1;
                end
            end
        end
    end

    // Target selection: manual switches, fail-safe cooling, or hysteresis
    always_comb begin
        // NOTE: defaults first so no path leaves a target unassigned (no latch).
        w_fan_target = r_fan_req;
        w_hum_target = r_hum_req;
        if (!r_mode_auto) begin
            w_fan_target = w_man_fan_sync;
            w_hum_target = w_man_hum_sync;
        end else if (r_fault) begin
            w_fan_target = 1'b1;
            w_hum_target = 1'b0;
        end
    end

    assign w_force = r_mode_auto && r_fault && !r_fault_d;

    actuator_dwell #(
        .MIN_DWELL_S (MIN_DWELL_S)
    ) u_fan_dwell (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick_1s   (w_tick_1s),
        .target    (w_fan_target),
        .force_en  (w_force),
        .force_val (1'b1),
        .state_out (w_fan_state)
    );

    actuator_dwell #(
        .MIN_DWELL_S (MIN_DWELL_S)
    ) u_hum_dwell (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick_1s   (w_tick_1s),
        .target    (w_hum_target),
        .force_en  (w_force),
        .force_val (1'b0),
        .state_out (w_hum_state)
    );

    assign mode_auto     = r_mode_auto;
    assign fan_on        = w_fan_state;
    assign hum_on        = w_hum_state;
    assign sensor_fault  = r_fault;
    assign sample_reject = r_sample_reject;

endmodule

// File: tb/tb_climate_ctrl.sv
// Scoreboard bench for climate_ctrl. A behavioural model predicts every
// change of the output vector {mode_auto, fan_on, hum_on, sensor_fault,
// sample_reject} and the clock edge it happens on; a monitor pops and
// compares each time the DUT outputs change.
module tb_climate_ctrl;

    localparam int CLK_HZ      = 1000;
    localparam int MIN_DWELL_S = 2;
    localparam int STALE_S     = 3;
    localparam int DEBOUNCE_MS = 2;
    localparam int MS_DIV      = CLK_HZ / 1000;
    localparam int T_ON  = 8;
    localparam int T_OFF = 5;
    localparam int H_ON  = 85;
    localparam int H_OFF = 92;
    localparam int T_MAX = 50;
    localparam int H_MAX = 100;
    localparam logic [4:0] RESET_VEC = 5'b10000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       sample_valid = 1'b0;
    logic [7:0] temperature = '0;
    logic [7:0] humidity = '0;
    logic       mode_btn = 1'b0;
    logic       man_fan = 1'b0;
    logic       man_hum = 1'b0;
    logic       mode_auto, fan_on, hum_on, sensor_fault, sample_reject;

    climate_ctrl #(
        .CLK_HZ(CLK_HZ), .TEMP_ON(T_ON), .TEMP_OFF(T_OFF), .HUM_ON(H_ON),
        .HUM_OFF(H_OFF), .TEMP_MAX(T_MAX), .MIN_DWELL_S(MIN_DWELL_S),
        .STALE_S(STALE_S), .DEBOUNCE_MS(DEBOUNCE_MS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid),
        .temperature(temperature), .humidity(humidity), .mode_btn(mode_btn),
        .man_fan(man_fan), .man_hum(man_hum), .mode_auto(mode_auto),
        .fan_on(fan_on), .hum_on(hum_on), .sensor_fault(sensor_fault),
        .sample_reject(sample_reject)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [4:0] vec;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass = 0;
    int   edge_cnt = 0;
    bit   monitor_on = 1'b0;

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual == expected) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (edge %0d)", name, actual, expected, edge_cnt);
    endtask

    // ---------------- behavioural reference model ----------------
    bit         m_mode, m_fan, m_hum, m_fault, m_fault_prev, m_rej;
    bit         m_fan_req, m_hum_req, m_btn_acc, m_btn_prev;
    int         m_btn_run, m_fan_chg, m_hum_chg, m_last_acc;
    bit [1:0]   m_btn_h, m_mf_h, m_mh_h;
    logic [4:0] m_last_vec;

    // True once MIN_DWELL_S second boundaries have passed strictly after
    // change edge c and strictly before edge e (c < 0: never changed).
    function automatic bit expired(input int c, input int e);
        if (c < 0) return 1'b1;
        return ((e - 1) / CLK_HZ - c / CLK_HZ) >= MIN_DWELL_S;
    endfunction

    task automatic model_reset();
        edge_cnt = 0;
        m_mode = 1'b1; m_fan = 1'b0; m_hum = 1'b0; m_fault = 1'b0;
        m_fault_prev = 1'b0; m_rej = 1'b0; m_fan_req = 1'b0; m_hum_req = 1'b0;
        m_btn_acc = 1'b0; m_btn_prev = 1'b0; m_btn_run = 0;
        m_fan_chg = -1; m_hum_chg = -1; m_last_acc = 0;
        m_btn_h = '0; m_mf_h = '0; m_mh_h = '0;
        m_last_vec = RESET_VEC;
    endtask

    task automatic model_step();
        int e;
        bit tick_s, tick_ms, acc, rej, s_btn, s_mf, s_mh, tf, th, frc;
        bit n_fan, n_hum, n_fault, n_mode;
        logic [4:0] vec;
        e = edge_cnt + 1;
        edge_cnt = e;
        tick_s  = (e % CLK_HZ) == 0;
        tick_ms = (e % MS_DIV) == 0;
        s_btn = m_btn_h[1]; s_mf = m_mf_h[1]; s_mh = m_mh_h[1];
        acc = sample_valid && (temperature <= T_MAX) && (humidity <= H_MAX);
        rej = sample_valid && !acc;
        if (!m_mode) begin tf = s_mf; th = s_mh; end
        else if (m_fault) begin tf = 1'b1; th = 1'b0; end
        else begin tf = m_fan_req; th = m_hum_req; end
        frc = m_mode && m_fault && !m_fault_prev;
        n_fan = m_fan;
        n_hum = m_hum;
        if (frc) begin
            n_fan = 1'b1; n_hum = 1'b0; m_fan_chg = e; m_hum_chg = e;
        end else begin
            if (tf != m_fan && expired(m_fan_chg, e)) begin n_fan = tf; m_fan_chg = e; end
            if (th != m_hum && expired(m_hum_chg, e)) begin n_hum = th; m_hum_chg = e; end
        end
        m_fault_prev = m_fault;
        if (acc) begin
            n_fault = 1'b0;
            m_last_acc = e;
            if (temperature >= T_ON) m_fan_req = 1'b1;
            else if (temperature <= T_OFF) m_fan_req = 1'b0;
            if (humidity <= H_ON) m_hum_req = 1'b1;
            else if (humidity >= H_OFF) m_hum_req = 1'b0;
        end else begin
            n_fault = m_fault || (tick_s && (e / CLK_HZ - m_last_acc / CLK_HZ) >= STALE_S);
        end
        n_mode = m_mode;
        if (tick_ms) begin
            if (s_btn == m_btn_prev) m_btn_run++;
            else m_btn_run = 1;
            m_btn_prev = s_btn;
            if (s_btn != m_btn_acc && m_btn_run >= DEBOUNCE_MS) begin
                m_btn_acc = s_btn;
                if (s_btn) n_mode = !m_mode;
            end
        end
        m_mode = n_mode; m_fan = n_fan; m_hum = n_hum; m_fault = n_fault; m_rej = rej;
        m_btn_h = {m_btn_h[0], mode_btn};
        m_mf_h  = {m_mf_h[0], man_fan};
        m_mh_h  = {m_mh_h[0], man_hum};
        vec = {m_mode, m_fan, m_hum, m_fault, m_rej};
        if (vec != m_last_vec) begin
            exp_q.push_back('{e, vec});
            m_last_vec = vec;
        end
    endtask

    always @(posedge clk) begin
        if (rst_n) model_reset();
        else model_step();
    end

    // ---------------- monitor ----------------
    logic [4:0] dut_vec;
    logic [4:0] last_dut_vec = RESET_VEC;
    exp_t       mon_ex;

    always @(negedge clk) begin
        if (monitor_on) begin
            dut_vec = {mode_auto, fan_on, hum_on, sensor_fault, sample_reject};
            if (dut_vec != last_dut_vec) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_change", int'(dut_vec), int'(last_dut_vec));
                end else begin
                    mon_ex = exp_q.pop_front();
                    check("out_vec", int'(dut_vec), int'(mon_ex.vec));
                    check("out_cycle", edge_cnt, mon_ex.cyc);
                end
                last_dut_vec = dut_vec;
            end
            while (exp_q.size() > 0 && exp_q[0].cyc < edge_cnt) begin
                mon_ex = exp_q.pop_front();
                check("missed_event_cycle", edge_cnt, mon_ex.cyc);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_sample(input int t, input int h);
        sample_valid = 1'b1;
        temperature  = 8'(t);
        humidity     = 8'(h);
        step(1);
        sample_valid = 1'b0;
    endtask

    task automatic press(input int len);
        mode_btn = 1'b1;
        step(len);
        mode_btn = 1'b0;
        step(DEBOUNCE_MS + 6);
    endtask

    int op;
    int tgt;

    initial begin
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_vec", int'({mode_auto, fan_on, hum_on, sensor_fault, sample_reject}), int'(RESET_VEC));
        @(negedge clk);
        rst_n = 1'b0;
        monitor_on = 1'b1;
        step(1);

        // First sample: fan on within 2 cycles, 90 %RH sits in the hold band
        send_sample(9, 90);
        step(1);
        check("first_fan_on", fan_on, 1);
        check("first_hum_hold", hum_on, 0);
        step(497);
        send_sample(6, 90);
        step(499);
        send_sample(4, 90);
        step(1500);

        // Implausible samples
        send_sample(60, 80);
        step(5);
        send_sample(20, 101);
        step(5);

        // Humidifier on, then let the sensor go stale
        send_sample(3, 80);
        step(200);
        step(3500);
        check("stale_fault", sensor_fault, 1);
        check("failsafe_fan", fan_on, 1);
        check("failsafe_hum", hum_on, 0);
        send_sample(3, 88);
        step(2500);

        // Mode button: glitch ignored, press toggles, manual switches drive
        mode_btn = 1'b1;
        step(1);
        mode_btn = 1'b0;
        step(10);
        check("glitch_mode", mode_auto, 1);
        press(5);
        check("manual_mode", mode_auto, 0);
        man_fan = 1'b1;
        step(2500);
        man_fan = 1'b0;
        step(300);
        man_hum = 1'b1;
        step(2500);
        press(5);
        check("auto_restored", mode_auto, 1);
        man_hum = 1'b0;
        step(100);

        // Accepted sample on the exact edge of the STALE_S-th tick
        send_sample(10, 90);
        tgt = (edge_cnt / CLK_HZ + STALE_S) * CLK_HZ;
        step(tgt - 1 - edge_cnt);
        send_sample(20, 90);
        step(1);
        check("coincident_no_fault", sensor_fault, 0);
        step(50);

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            op = $urandom_range(0, 9);
            if (op <= 4) begin
                if ($urandom_range(0, 3) == 0)
                    send_sample($urandom_range(0, 60), $urandom_range(0, 105));
                else
                    send_sample($urandom_range(2, 11), $urandom_range(80, 96));
                step($urandom_range(1, 600));
            end else if (op == 5) begin
                man_fan = 1'($urandom_range(0, 1));
                man_hum = 1'($urandom_range(0, 1));
                step($urandom_range(1, 300));
            end else if (op == 6) begin
                press($urandom_range(1, 6));
            end else if (op == 7) begin
                step($urandom_range(2500, 4000));
            end else begin
                step($urandom_range(1, 50));
            end
        end

        // Leave the block away from its reset state, then reset asynchronously
        if (m_mode) press(5);
        step(20);
        check("queue_drained", exp_q.size(), 0);
        monitor_on = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        check("async_reset", int'({mode_auto, fan_on, hum_on, sensor_fault, sample_reject}), int'(RESET_VEC));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
